// File: rtl/df_deadlock_detector_if.sv
// Handshake and stall bundle between the dataflow processes and the deadlock watchdog.
// The master side drives process status; the slave side is the detector.
interface df_deadlock_detector_if #(
  parameter int unsigned NUM_PROC = 4,
  parameter int unsigned CNT_W    = 32
);
  logic [NUM_PROC-1:0] proc_start;
  logic [NUM_PROC-1:0] proc_done;
  logic [NUM_PROC-1:0] proc_continue;
  logic [NUM_PROC-1:0] proc_in_stall;
  logic [NUM_PROC-1:0] proc_out_stall;
  logic                finish;
  logic                clear;
  logic                find_df_deadlock;
  logic [NUM_PROC-1:0] deadlock_mask;
  logic [CNT_W-1:0]    deadlock_cycle;
  logic [CNT_W-1:0]    blocked_cycles;

  modport master (
    output proc_start, proc_done, proc_continue, proc_in_stall, proc_out_stall,
    output finish, clear,
    input  find_df_deadlock, deadlock_mask, deadlock_cycle, blocked_cycles
  );

  modport slave (
    input  proc_start, proc_done, proc_continue, proc_in_stall, proc_out_stall,
    input  finish, clear,
    output find_df_deadlock, deadlock_mask, deadlock_cycle, blocked_cycles
  );
endinterface

// File: rtl/df_deadlock_detector.sv
// Dataflow deadlock watchdog: declares a sticky deadlock once every active
// process has been blocked, with no completion, for THRESHOLD consecutive cycles.
module df_deadlock_detector #(
  parameter int unsigned NUM_PROC  = 4,
  parameter int unsigned THRESHOLD = 1000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  df_deadlock_detector_if.slave mon
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    SUSPECT  = 3'd2,
    DEADLOCK = 3'd3,
    FINISHED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  state_t              state_q;
  logic [NUM_PROC-1:0] active_q;
  logic [CNT_W-1:0]    cycle_q;
  logic                flag_q;
  logic [NUM_PROC-1:0] mask_q;
  logic [CNT_W-1:0]    dl_cycle_q;
  logic [CNT_W-1:0]    blk_q;

  logic [NUM_PROC-1:0] active_nxt;
  logic [NUM_PROC-1:0] blocked;
  logic                all_blocked;
  logic                progress;
  logic                stuck;
  logic [CNT_W-1:0]    blk_inc;

  // Process activity tracking and the all-blocked / progress qualifiers
  always_comb begin
    active_nxt  = mon.proc_start | (active_q & ~(mon.proc_done & mon.proc_continue));
    blocked     = active_q & (mon.proc_in_stall | mon.proc_out_stall) & ~mon.proc_done;
    all_blocked = (|active_q) && (blocked == active_q);
    progress    = |mon.proc_done;
    stuck       = all_blocked && !progress;
    blk_inc     = (blk_q == '1) ? blk_q : blk_q + CNT_W'(1);
  end

  // Activity vector and free-running saturating cycle counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      cycle_q  <= '0;
    end else begin
      active_q <= active_nxt;
      if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  // Detection FSM; all reported values are updated here and frozen outside RUN/SUSPECT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      flag_q     <= 1'b0;
      mask_q     <= '0;
      dl_cycle_q <= '0;
      blk_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mon.finish)          state_q <= FINISHED;
          else if (|mon.proc_start) state_q <= RUN;
        end
        RUN: begin
          if (mon.finish) begin
            state_q <= FINISHED;
          end else if (stuck) begin
            blk_q <= CNT_W'(1);
            if (THR <= CNT_W'(1)) begin
              state_q    <= DEADLOCK;
              flag_q     <= 1'b1;
              mask_q     <= blocked;
              dl_cycle_q <= cycle_q;
            end else begin
              state_q <= SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (mon.finish) begin
            state_q <= FINISHED;
          end else if (stuck) begin
            blk_q <= blk_inc;
            if (blk_inc >= THR) begin
              state_q    <= DEADLOCK;
              flag_q     <= 1'b1;
              mask_q     <= blocked;
              dl_cycle_q <= cycle_q;
            end
          end else begin
            state_q <= RUN;
            blk_q   <= '0;
          end
        end
        DEADLOCK: begin
          // clear outranks a concurrent finish here
          if (mon.clear) begin
            state_q <= IDLE;
            flag_q  <= 1'b0;
            blk_q   <= '0;
          end
        end
        FINISHED: begin
          if (mon.clear) begin
            state_q <= IDLE;
            blk_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mon.find_df_deadlock = flag_q;
  assign mon.deadlock_mask    = mask_q;
  assign mon.deadlock_cycle   = dl_cycle_q;
  assign mon.blocked_cycles   = blk_q;

endmodule

// File: doc/df_deadlock_detector.md
# df_deadlock_detector

Synthesizable dataflow deadlock watchdog sitting directly upstream of the dataflow process/module monitors in the simulation testbench. It observes the ap_ctrl handshake and stall indications of every dataflow process in the design under test, declares a deadlock when all active processes have been blocked with no completion for a programmable window, and drives the sticky `find_df_deadlock` flag that the monitors use to terminate sampling and start their CSV dumps. It also reports which processes were blocked and the cycle at which deadlock was declared.

## Interface
- `NUM_PROC`, 4: number of dataflow processes observed (1..32).
- `THRESHOLD`, 1000: consecutive all-blocked cycles required to declare deadlock (>= 1).
- `CNT_W`, 32: width of the cycle counter and timestamp outputs.

- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `proc_start`  in  NUM_PROC  ap_start of each process.
- `proc_done`  in  NUM_PROC  ap_done of each process.
- `proc_continue`  in  NUM_PROC  ap_continue of each process.
- `proc_in_stall`  in  NUM_PROC  process blocked reading an empty channel.
- `proc_out_stall`  in  NUM_PROC  process blocked writing a full channel.
- `finish`  in  1  testbench end-of-run; stops detection.
- `clear`  in  1  synchronous return to IDLE from DEADLOCK/FINISHED.
- `find_df_deadlock`  out  1  sticky deadlock flag.
- `deadlock_mask`  out  NUM_PROC  blocked vector latched at declaration.
- `deadlock_cycle`  out  CNT_W  cycle-counter value latched at declaration.
- `blocked_cycles`  out  CNT_W  current consecutive all-blocked count.

## Operation
- Per-process `active[i]`: next = `proc_start[i]` | (`active[i]` & !(`proc_done[i]` & `proc_continue[i]`)). Start and retiring done in the same cycle leaves the process active.
- `blocked[i]` = `active[i]` & (`proc_in_stall[i]` | `proc_out_stall[i]`) & !`proc_done[i]`.
- `all_blocked` = (|`active`) & (`blocked` == `active`). `progress` = |`proc_done`.
- Cycle counter: counts every cycle after reset release; saturates at 2^CNT_W-1.
- States:
  - IDLE: wait for |`proc_start` -> RUN.
  - RUN: `all_blocked` & !`progress` -> SUSPECT, `blocked_cycles` <= 1.
  - SUSPECT: each cycle with `all_blocked` & !`progress`, `blocked_cycles` increments (saturating); otherwise -> RUN, `blocked_cycles` <= 0. Count reaching THRESHOLD -> DEADLOCK, latch `deadlock_mask` <= `blocked` and `deadlock_cycle` <= cycle counter.
  - DEADLOCK: `find_df_deadlock` = 1; all outputs frozen; exits only on `clear` (-> IDLE) or reset.
  - FINISHED: entered from IDLE/RUN/SUSPECT when `finish` = 1; outputs frozen, no detection; `clear` -> IDLE.
- With THRESHOLD = 1, RUN transitions directly to DEADLOCK on the first all-blocked cycle.
- `clear` in IDLE/RUN/SUSPECT: no effect.

## Timing
- Reset (async assert, sync release): state IDLE, `active` = 0, `find_df_deadlock` = 0, `deadlock_mask` = 0, `deadlock_cycle` = 0, `blocked_cycles` = 0, cycle counter = 0.
- All outputs registered. If `all_blocked` & !`progress` holds on cycles t .. t+THRESHOLD-1, `find_df_deadlock` is high from the edge ending cycle t+THRESHOLD-1 onward (visible in cycle t+THRESHOLD).
- A single `proc_done` pulse, or any active process unblocking, in the window resets the count; the next all-blocked cycle restarts at 1.
- `finish` and threshold reached in the same cycle: `finish` wins -> FINISHED, `find_df_deadlock` stays 0.
- `clear` and `finish` in the same cycle in DEADLOCK: `clear` wins -> IDLE.
- Reset asserted mid-SUSPECT or in DEADLOCK: immediately returns all outputs to reset values.

## Test plan
- Normal run, NUM_PROC=4, THRESHOLD=8: each process start/done/continue with stalls <= 3 cycles, then `finish` -> `find_df_deadlock` never asserts; state FINISHED.
- Deadlock: all 4 started, funcB/funcC `proc_out_stall`=1, funcA/funcD `proc_in_stall`=1, held -> flag high exactly 8 cycles after first all-blocked cycle; `deadlock_mask` = 4'b1111; `deadlock_cycle` = counter at declaration.
- Near miss: all blocked 7 cycles, one `proc_done` pulse, then all blocked 8 cycles -> flag rises only at end of the second window; `blocked_cycles` drops to 0 after the pulse.
- Partial activity: only processes 0 and 2 active and blocked for 8 cycles -> deadlock, `deadlock_mask` = 4'b0101.
- Simultaneous: `finish` asserted on the cycle the count reaches 8 -> flag stays 0; then `clear` -> IDLE; new start restarts detection.
- Async reset mid-SUSPECT (count = 5): all outputs 0 immediately, state IDLE after release.
